// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage.
// Contents: ALU op codes, branch funct codes, multiply/divide funct codes,
//           forwarding select codes and the iterative mul/div FSM state type.
// Related configuration macro: MULDIV_EN (enables the iterative mul/div unit).
package exec_pkg;

  // ALU operation select (alu_ctrl_e); codes 10-15 produce zero
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSlt  = 4'd5;
  localparam logic [3:0] AluSltu = 4'd6;
  localparam logic [3:0] AluSll  = 4'd7;
  localparam logic [3:0] AluSrl  = 4'd8;
  localparam logic [3:0] AluSra  = 4'd9;

  // Branch condition select (br_funct_e); 010/011 never taken
  localparam logic [2:0] BrEq  = 3'b000;
  localparam logic [2:0] BrNe  = 3'b001;
  localparam logic [2:0] BrLt  = 3'b100;
  localparam logic [2:0] BrGe  = 3'b101;
  localparam logic [2:0] BrLtu = 3'b110;
  localparam logic [2:0] BrGeu = 3'b111;

  // Multiply/divide select (md_funct_e); 001/010 produce zero
  localparam logic [2:0] MdMul   = 3'b000;
  localparam logic [2:0] MdMulhu = 3'b011;
  localparam logic [2:0] MdDiv   = 3'b100;
  localparam logic [2:0] MdDivu  = 3'b101;
  localparam logic [2:0] MdRem   = 3'b110;
  localparam logic [2:0] MdRemu  = 3'b111;

  // Forwarding select; 11 behaves like 00
  localparam logic [1:0] FwdRf = 2'b00;
  localparam logic [1:0] FwdW  = 2'b01;
  localparam logic [1:0] FwdM  = 2'b10;

  typedef enum logic [1:0] {MdIdle, MdBusy, MdDone} md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: one shift-add (multiply) or restoring-divide
// step per cycle on operand magnitudes, XLEN steps per operation.
// Compiled only when MULDIV_EN is defined.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           an MD instruction is present (accepted only in idle)
//   flush           abandon any operation, return to idle
//   hold            downstream stall; keeps the finished result in done
//   a, b            forwarded operands (latched on accept)
//   funct           M-op select (latched on accept)
//   done            unit is in its done state; result is valid
//   result          final product/quotient/remainder
`ifdef MULDIV_EN
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  // hi: multiply accumulator / partial remainder; lo: multiplier / quotient
  logic [XLEN-1:0] hi_q, lo_q;
  // d: multiplicand or divisor magnitude
  logic [XLEN-1:0] d_q;
  // original operands, kept for sign fix-up and divide-by-zero
  logic [XLEN-1:0] a_q, b_q;
  logic [2:0]      funct_q;

  logic            signed_div;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift, div_diff;

  assign signed_div = (funct == MdDiv) || (funct == MdRem);
  assign a_neg      = signed_div & a[XLEN-1];
  assign b_neg      = signed_div & b[XLEN-1];
  assign a_mag      = a_neg ? -a : a;
  assign b_mag      = b_neg ? -b : b;

  assign mul_sum   = {1'b0, hi_q} + {1'b0, {XLEN{lo_q[0]}} & d_q};
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  // MSB of the difference is the borrow: set means the divisor did not fit
  assign div_diff  = div_shift - {1'b0, d_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      d_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      funct_q <= '0;
    end else if (flush) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        MdIdle: begin
          if (start) begin
            state_q <= MdBusy;
            cnt_q   <= '0;
            a_q     <= a;
            b_q     <= b;
            funct_q <= funct;
            hi_q    <= '0;
            if (funct[2]) begin
              lo_q <= a_mag;
              d_q  <= b_mag;
            end else begin
              lo_q <= b;
              d_q  <= a;
            end
          end
        end
        MdBusy: begin
          if (funct_q[2]) begin
            if (div_diff[XLEN]) begin
              hi_q <= div_shift[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], 1'b0};
            end else begin
              hi_q <= div_diff[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], 1'b1};
            end
          end else begin
            {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= MdDone;
          end
        end
        MdDone: begin
          if (!hold) begin
            state_q <= MdIdle;
          end
        end
        default: state_q <= MdIdle;
      endcase
    end
  end

  logic q_neg, b_zero;
  assign q_neg  = a_q[XLEN-1] ^ b_q[XLEN-1];
  assign b_zero = (b_q == '0);
  assign done   = (state_q == MdDone);

  // min / -1 needs no special case: |min| negated wraps back to min, remainder 0
  always_comb begin
    result = '0;
    case (funct_q)
      MdMul:   result = lo_q;
      MdMulhu: result = hi_q;
      MdDiv:   result = b_zero ? '1 : (q_neg ? -lo_q : lo_q);
      MdDivu:  result = b_zero ? '1 : lo_q;
      MdRem:   result = b_zero ? a_q : (a_q[XLEN-1] ? -hi_q : hi_q);
      MdRemu:  result = b_zero ? a_q : hi_q;
      default: result = '0;
    endcase
  end

endmodule
`endif

// File: rtl/execute_stage_md.sv
// Pipelined RISC-V execute stage: operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register with valid/stall/flush.
// Optional iterative multiply/divide unit enabled by the macro MULDIV_EN;
// without it, md_op_e only forces alu_result_m to zero.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid_e, *_e controls    decoded ID/EX contents
//   rd1_e, rd2_e, imm_ext_e     register operands and immediate
//   pc_e, pc_plus4_e, result_w  PC values and writeback forwarding source
//   fwd_a_e, fwd_b_e            forwarding selects
//   stall_m, flush_e            hold EX/MEM / kill the EX instruction
//   stall_e                     hold upstream stages
//   pc_src_e, pc_target_e       fetch redirect and target
//   *_m                         EX/MEM register outputs
module execute_stage_md
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic            alu_src_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic            md_op_e,
  input  logic [1:0]      result_src_e,
  input  logic [3:0]      alu_ctrl_e,
  input  logic [2:0]      br_funct_e,
  input  logic [2:0]      md_funct_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [XLEN-1:0] result_w,
  input  logic [RA_W-1:0] rd_e,
  input  logic [1:0]      fwd_a_e,
  input  logic [1:0]      fwd_b_e,
  input  logic            stall_m,
  input  logic            flush_e,
  output logic            stall_e,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            valid_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m,
  output logic [RA_W-1:0] rd_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] alu_result_m
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic [XLEN-1:0] src_a, src_b_fwd, src_b;
  logic [XLEN-1:0] alu_result, md_result;
  logic [ShW-1:0]  shamt;
  logic            br_cond;

  always_comb begin
    case (fwd_a_e)
      FwdW:    src_a = result_w;
      FwdM:    src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
    case (fwd_b_e)
      FwdW:    src_b_fwd = result_w;
      FwdM:    src_b_fwd = alu_result_m;
      default: src_b_fwd = rd2_e;
    endcase
  end

  assign src_b = alu_src_e ? imm_ext_e : src_b_fwd;
  assign shamt = src_b[ShW-1:0];

  always_comb begin
    alu_result = '0;
    case (alu_ctrl_e)
      AluAdd:  alu_result = src_a + src_b;
      AluSub:  alu_result = src_a - src_b;
      AluAnd:  alu_result = src_a & src_b;
      AluOr:   alu_result = src_a | src_b;
      AluXor:  alu_result = src_a ^ src_b;
      AluSlt:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      AluSltu: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      AluSll:  alu_result = src_a << shamt;
      AluSrl:  alu_result = src_a >> shamt;
      AluSra:  alu_result = $unsigned($signed(src_a) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  // Branches compare against the register operand, never the immediate
  always_comb begin
    br_cond = 1'b0;
    case (br_funct_e)
      BrEq:    br_cond = (src_a == src_b_fwd);
      BrNe:    br_cond = (src_a != src_b_fwd);
      BrLt:    br_cond = ($signed(src_a) <  $signed(src_b_fwd));
      BrGe:    br_cond = ($signed(src_a) >= $signed(src_b_fwd));
      BrLtu:   br_cond = (src_a <  src_b_fwd);
      BrGeu:   br_cond = (src_a >= src_b_fwd);
      default: br_cond = 1'b0;
    endcase
  end

  assign pc_src_e    = in_valid_e & ~stall_m & ~flush_e & (jump_e | (branch_e & br_cond));
  assign pc_target_e = pc_e + imm_ext_e;

`ifdef MULDIV_EN
  logic md_done;

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (in_valid_e & md_op_e),
    .flush  (flush_e),
    .hold   (stall_m),
    .a      (src_a),
    .b      (src_b_fwd),
    .funct  (md_funct_e),
    .done   (md_done),
    .result (md_result)
  );

  // Upstream holds the MD instruction until its done cycle
  assign stall_e = ~rst & (stall_m | (in_valid_e & md_op_e & ~md_done));
`else
  logic unused_md_funct;
  assign unused_md_funct = ^md_funct_e;
  assign md_result       = '0;
  assign stall_e         = ~rst & stall_m;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
      rd_m         <= '0;
      pc_plus4_m   <= '0;
      write_data_m <= '0;
      alu_result_m <= '0;
    end else if (!stall_m) begin
      if (flush_e || stall_e) begin
        valid_m     <= 1'b0;
        reg_write_m <= 1'b0;
        mem_write_m <= 1'b0;
      end else begin
        valid_m      <= in_valid_e;
        reg_write_m  <= reg_write_e;
        mem_write_m  <= mem_write_e;
        result_src_m <= result_src_e;
        rd_m         <= rd_e;
        pc_plus4_m   <= pc_plus4_e;
        write_data_m <= src_b_fwd;
        alu_result_m <= md_op_e ? md_result : alu_result;
      end
    end
  end

endmodule
